fifo_read_chk: RTL and testbench

FIFO_READ_CHK -- requirements
Module: fifo_read_chk

---
 rtl/fifo_rw_pkg.sv | 15 +
 rtl/fifo_seq_chk.sv | 42 ++++
 rtl/fifo_read_chk.sv | 143 ++++++++++++++
 tb/tb_fifo_read_chk.sv | 293 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_rw_pkg.sv
// Shared types and default parameters for the FIFO read-burst checker.
package fifo_rw_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WAIT  = 2'd1,
        READ  = 2'd2,
        DRAIN = 2'd3
    } rd_state_t;

    localparam int DATA_W_DEF    = 8;
    localparam int DELAY_CYC_DEF = 10;
    localparam int RD_LAT_DEF    = 1;

endpackage

// File: rtl/fifo_seq_chk.sv
// Sequence checker: every word after the first of a burst must be prev+1 or 0.
module fifo_seq_chk
    import fifo_rw_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic              sys_clk,
    input  logic              sys_rst,
    input  logic              first,
    input  logic              valid,
    input  logic [DATA_W-1:0] data,
    output logic              data_err,
    output logic [7:0]        err_cnt
);

    logic [DATA_W-1:0] ref_q;
    logic [DATA_W-1:0] succ;
    logic              mismatch;

    assign succ     = ref_q + DATA_W'(1);
    // A zero word is a legal writer restart, not an error.
    assign mismatch = valid && !first && (data != succ) && (data != '0);

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            ref_q    <= '0;
            data_err <= 1'b0;
            err_cnt  <= '0;
        end else begin
            if (valid) begin
                ref_q <= data;
            end
            if (mismatch) begin
                data_err <= 1'b1;
                if (err_cnt != 8'hFF) begin
                    err_cnt <= err_cnt + 8'd1;
                end
            end
        end
    end

endmodule

// File: rtl/fifo_read_chk.sv
// Waits for almost_full to rise, settles, then drains the FIFO in one burst
// and checks that the words read back form an incrementing sequence.
module fifo_read_chk
    import fifo_rw_pkg::*;
#(
    parameter int DATA_W    = DATA_W_DEF,
    parameter int DELAY_CYC = DELAY_CYC_DEF,
    parameter int RD_LAT    = RD_LAT_DEF
) (
    input  logic              sys_clk,
    input  logic              sys_rst,
    input  logic              almost_full,
    input  logic              almost_empty,
    input  logic              fifo_empty,
    input  logic [DATA_W-1:0] fifo_rdata,
    output logic              fifo_rd_en,
    output logic [DATA_W-1:0] out_data,
    output logic              out_valid,
    output logic              rd_busy,
    output logic              data_err,
    output logic [7:0]        err_cnt,
    output logic [7:0]        burst_cnt
);

    localparam int CNT_MAX = (DELAY_CYC > RD_LAT) ? DELAY_CYC : RD_LAT;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    rd_state_t         state_q;
    logic              af_s1_q, af_s2_q;
    logic              trig, stop;
    logic [CNT_W-1:0]  cnt_q, cnt_inc;
    logic              rd_en_q, busy_q, first_q;
    logic [7:0]        burst_q;
    logic [RD_LAT-1:0] vpipe_q, vpipe_d;
    logic              cap;
    logic              out_valid_q;
    logic [DATA_W-1:0] out_data_q;

    assign trig    = af_s1_q & ~af_s2_q;
    assign stop    = almost_empty | fifo_empty;
    assign cnt_inc = cnt_q + CNT_W'(1);
    assign cap     = vpipe_q[RD_LAT-1];

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            state_q <= IDLE;
            af_s1_q <= 1'b0;
            af_s2_q <= 1'b0;
            cnt_q   <= '0;
            rd_en_q <= 1'b0;
            busy_q  <= 1'b0;
            first_q <= 1'b0;
            burst_q <= '0;
        end else begin
            af_s1_q <= almost_full;
            af_s2_q <= af_s1_q;
            if (cap) begin
                first_q <= 1'b0;
            end
            case (state_q)
                IDLE: begin
                    if (trig) begin
                        state_q <= WAIT;
                        cnt_q   <= '0;
                        busy_q  <= 1'b1;
                        first_q <= 1'b1;
                    end
                end
                WAIT: begin
                    cnt_q <= cnt_inc;
                    if (cnt_inc == CNT_W'(DELAY_CYC)) begin
                        state_q <= READ;
                        rd_en_q <= ~fifo_empty;
                    end
                end
                READ: begin
                    // Flags are sampled here, so one read may already be in flight.
                    if (stop) begin
                        rd_en_q <= 1'b0;
                        cnt_q   <= '0;
                        state_q <= DRAIN;
                    end else begin
                        rd_en_q <= 1'b1;
                    end
                end
                DRAIN: begin
                    cnt_q <= cnt_inc;
                    if (cnt_inc == CNT_W'(RD_LAT)) begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                        burst_q <= burst_q + 8'd1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // Valid pipeline: rd_en delayed by RD_LAT marks when fifo_rdata is live.
    genvar gi;
    generate
        for (gi = 0; gi < RD_LAT; gi++) begin : g_vpipe
            if (gi == 0) begin : g_head
                assign vpipe_d[gi] = rd_en_q;
            end else begin : g_tail
                assign vpipe_d[gi] = vpipe_q[gi-1];
            end
        end
    endgenerate

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            vpipe_q     <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
        end else begin
            vpipe_q     <= vpipe_d;
            out_valid_q <= cap;
            if (cap) begin
                out_data_q <= fifo_rdata;
            end
        end
    end

    fifo_seq_chk #(
        .DATA_W (DATA_W)
    ) u_seq_chk (
        .sys_clk  (sys_clk),
        .sys_rst  (sys_rst),
        .first    (first_q),
        .valid    (cap),
        .data     (fifo_rdata),
        .data_err (data_err),
        .err_cnt  (err_cnt)
    );

    assign fifo_rd_en = rd_en_q;
    assign out_data   = out_data_q;
    assign out_valid  = out_valid_q;
    assign rd_busy    = busy_q;
    assign burst_cnt  = burst_q;

endmodule

// File: tb/tb_fifo_read_chk.sv
// Bench for fifo_read_chk: 16-deep FIFO model, scoreboard of popped words and
// a sequence-rule model checked every cycle, plus directed burst scenarios.
module tb_fifo_read_chk;

    localparam int DELAY_CYC = 10;
    localparam int RD_LAT    = 1;

    logic       clk = 1'b0;
    logic       sys_rst;
    logic       almost_full, almost_empty, fifo_empty;
    logic [7:0] fifo_rdata = 8'h00;
    logic       fifo_rd_en, out_valid, rd_busy, data_err;
    logic [7:0] out_data, err_cnt, burst_cnt;

    always #5 clk = ~clk;

    fifo_read_chk #(
        .DATA_W    (8),
        .DELAY_CYC (DELAY_CYC),
        .RD_LAT    (RD_LAT)
    ) dut (
        .sys_clk      (clk),
        .sys_rst      (sys_rst),
        .almost_full  (almost_full),
        .almost_empty (almost_empty),
        .fifo_empty   (fifo_empty),
        .fifo_rdata   (fifo_rdata),
        .fifo_rd_en   (fifo_rd_en),
        .out_data     (out_data),
        .out_valid    (out_valid),
        .rd_busy      (rd_busy),
        .data_err     (data_err),
        .err_cnt      (err_cnt),
        .burst_cnt    (burst_cnt)
    );

    int total = 0;
    int bad   = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h want=%0h @%0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- FIFO model (depth 16) and popped-word scoreboard
    typedef struct {
        int         due;
        logic [7:0] d;
    } exp_t;

    exp_t       exp_q[$];
    logic [7:0] mem[16];
    logic [3:0] wp = 4'd0, rp = 4'd0;
    int         fcnt = 0;
    int         cyc  = 0;
    logic       rst_seen = 1'b1;
    logic       wr_en, af_pulse;
    logic [7:0] wr_data;

    assign almost_full  = (fcnt >= 15) | af_pulse;
    assign almost_empty = (fcnt <= 1);
    assign fifo_empty   = (fcnt == 0);

    always @(posedge clk) begin
        rst_seen <= sys_rst;
        cyc      <= cyc + 1;
        if (sys_rst) begin
            fcnt <= 0;
            wp   <= 4'd0;
            rp   <= 4'd0;
            exp_q.delete();
        end else begin
            if (fifo_rd_en && fcnt != 0) begin
                fifo_rdata <= mem[rp];
                rp         <= rp + 4'd1;
                // Word lands in fifo_rdata after RD_LAT, then one capture register.
                exp_q.push_back('{due: cyc + RD_LAT + 1, d: mem[rp]});
            end
            if (wr_en) begin
                mem[wp] <= wr_data;
                wp      <= wp + 4'd1;
            end
            fcnt <= fcnt + (wr_en ? 1 : 0) - ((fifo_rd_en && fcnt != 0) ? 1 : 0);
        end
    end

    // ---------------- per-cycle compare against the behavioural model
    logic [7:0] mref, mcnt, mburst;
    logic       merr, prev_v, exp_v;
    exp_t       e;

    initial begin
        forever begin
            @(negedge clk);
            if (rst_seen) begin
                mref = 8'h00; merr = 1'b0; mcnt = 8'h00; mburst = 8'h00; prev_v = 1'b0;
            end else begin
                exp_v = (exp_q.size() != 0) && (exp_q[0].due == cyc);
                chk("out_valid", out_valid, exp_v);
                if (exp_v) begin
                    e = exp_q.pop_front();
                    chk("out_data", out_data, e.d);
                    if (prev_v) begin
                        if (e.d != 8'(mref + 8'd1) && e.d != 8'h00) begin
                            merr = 1'b1;
                            if (mcnt != 8'hFF) mcnt = mcnt + 8'd1;
                        end
                    end
                    mref = e.d;
                end
                if (prev_v && !exp_v) begin
                    mburst = mburst + 8'd1;
                    chk("burst_cnt_end", burst_cnt, mburst);
                end
                prev_v = exp_v;
                chk("data_err", data_err, merr);
                chk("err_cnt", err_cnt, mcnt);
                if (fifo_rd_en) chk("rd_on_empty", fifo_empty, 1'b0);
            end
        end
    end

    // ---------------- stimulus helpers
    logic [7:0] bw[15];
    logic [7:0] got[32];
    int         nw, extra, rd_cyc, t, t_busy, t_rden, t_fall, t_idle, nburst = 0;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic step_s();
        step();
        t++;
        if (out_valid && nw < 32) begin
            got[nw] = out_data;
            nw++;
        end
    endtask

    task automatic chk_zero_outputs(input string tag);
        chk({tag, "_rd_en"},     fifo_rd_en, 1'b0);
        chk({tag, "_out_valid"}, out_valid,  1'b0);
        chk({tag, "_out_data"},  out_data,   8'h00);
        chk({tag, "_rd_busy"},   rd_busy,    1'b0);
        chk({tag, "_data_err"},  data_err,   1'b0);
        chk({tag, "_err_cnt"},   err_cnt,    8'h00);
        chk({tag, "_burst_cnt"}, burst_cnt,  8'h00);
    endtask

    task automatic run_burst(input int pulse_at, input int rst_at, input int idle_cyc);
        int g;
        nw = 0; extra = 0; rd_cyc = 0; t = 0;
        for (int i = 0; i < 15; i++) begin
            wr_en   = 1'b1;
            wr_data = bw[i];
            step_s();
        end
        wr_en = 1'b0;
        t = 0;
        g = 0;
        while (!rd_busy && g < 50) begin step_s(); g++; end
        chk("busy_rise", rd_busy, 1'b1);
        t_busy = t;
        g = 0;
        while (!fifo_rd_en && g < 50) begin step_s(); g++; end
        chk("rden_rise", fifo_rd_en, 1'b1);
        t_rden = t;
        g = 0;
        while (fifo_rd_en && g < 100) begin
            rd_cyc++;
            if (almost_empty) extra++;
            af_pulse = (rd_cyc == pulse_at);
            if (rd_cyc == rst_at) begin
                af_pulse = 1'b0;
                sys_rst  = 1'b1;
                step();
                chk_zero_outputs("midrst");
                sys_rst = 1'b0;
                step();
                step();
                chk("midrst_no_valid", out_valid, 1'b0);
                $display("burst %0d: reset after %0d reads", nburst, rd_cyc);
                nburst++;
                return;
            end
            step_s();
            g++;
        end
        af_pulse = 1'b0;
        chk("rden_fall", fifo_rd_en, 1'b0);
        t_fall = t;
        g = 0;
        while (rd_busy && g < 50) begin step_s(); g++; end
        chk("busy_fall", rd_busy, 1'b0);
        t_idle = t;
        for (int i = 0; i < idle_cyc; i++) begin
            step_s();
            chk("no_rewait", rd_busy, 1'b0);
        end
        $display("burst %0d: reads=%0d words=%0d extra=%0d err_cnt=%0d burst_cnt=%0d",
                 nburst, rd_cyc, nw, extra, err_cnt, burst_cnt);
        nburst++;
    endtask

    // ---------------- scenarios
    initial begin
        logic [7:0] cur;
        int         r;
        sys_rst = 1'b1; wr_en = 1'b0; wr_data = 8'h00; af_pulse = 1'b0;
        step(); step();
        chk_zero_outputs("reset");
        sys_rst = 1'b0;
        step();

        // Single clean burst 0..14
        for (int i = 0; i < 15; i++) bw[i] = 8'(i);
        run_burst(0, 0, 20);
        chk("trig_latency", t_busy, 2);
        chk("wait_len", t_rden - t_busy, DELAY_CYC);
        chk("drain_len", t_idle - t_fall, RD_LAT);
        chk("reads", rd_cyc, 15);
        chk("extra_read", extra, 1);
        chk("words", nw, 15);
        for (int i = 0; i < 15; i++) chk("word_order", got[i], i);
        chk("burst1_cnt", burst_cnt, 8'd1);
        chk("burst1_err", data_err, 1'b0);

        // Error injection: 0x07 in place of 0x05
        for (int i = 0; i < 15; i++) bw[i] = 8'(i);
        bw[5] = 8'h07;
        run_burst(0, 0, 4);
        chk("inj_err", data_err, 1'b1);
        chk("inj_cnt", err_cnt, 8'd2);
        chk("inj_burst", burst_cnt, 8'd2);

        // Trigger pulse during READ is ignored
        for (int i = 0; i < 15; i++) bw[i] = 8'(i);
        run_burst(5, 0, 20);
        chk("ign_burst", burst_cnt, 8'd3);
        chk("sticky_err", data_err, 1'b1);
        chk("sticky_cnt", err_cnt, 8'd2);

        // Reset mid-burst, then a fresh burst
        run_burst(0, 6, 0);
        for (int i = 0; i < 15; i++) bw[i] = 8'(20 + i);
        run_burst(0, 0, 4);
        chk("fresh_words", nw, 15);
        chk("fresh_burst", burst_cnt, 8'd1);
        chk("fresh_err", data_err, 1'b0);
        chk("fresh_cnt", err_cnt, 8'd0);

        // Saturation and wrap: constant bursts force 14 mismatches each
        sys_rst = 1'b1;
        step();
        sys_rst = 1'b0;
        step();
        for (int b = 0; b < 256; b++) begin
            if (b < 25) begin
                for (int i = 0; i < 15; i++) bw[i] = 8'hA5;
            end else begin
                cur = 8'($urandom_range(0, 255));
                for (int i = 0; i < 15; i++) begin
                    r = $urandom_range(0, 7);
                    if (r == 0)           cur = 8'h00;
                    else if (r == 1)      cur = 8'($urandom);
                    else if (i > 0)       cur = cur + 8'd1;
                    bw[i] = cur;
                end
            end
            run_burst(0, 0, 2);
            if (b == 24) chk("sat_cnt_early", err_cnt, 8'hFF);
            if (b == 254) chk("burst_255", burst_cnt, 8'hFF);
        end
        chk("sat_cnt", err_cnt, 8'hFF);
        chk("sat_err", data_err, 1'b1);
        chk("burst_wrap", burst_cnt, 8'h00);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: got=timeout want=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
